// File: rtl/dlfloat_mac_seq_if.sv
// Handshake bundle between the DLFloat16 dot-product sequencer, its operand/result
// ports and the MAC datapath. The sequencer uses the slave modport.
interface dlfloat_mac_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [15:0]      mac_c;
    logic             res_valid;
    logic [15:0]      res_data;
    logic             res_ready;

    modport master (
        output start, len, in_valid, in_data, mac_c, res_ready,
        input  busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data
    );

    modport slave (
        input  start, len, in_valid, in_data, mac_c, res_ready,
        output busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data
    );
endinterface

// File: rtl/dlfloat_mac_seq.sv
// Length-controlled dot-product job sequencer feeding a DLFloat16 MAC.
// Define DLFLOAT_SEQ_ZERO_SKIP_EN to skip non-first pairs that have a zero operand.
module dlfloat_mac_seq #(
    parameter int MAC_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    dlfloat_mac_seq_if.slave   bus
);
    localparam int WAIT_W = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              first_q, first_d;
    logic [15:0]       a_reg_q, a_reg_d;
    logic [15:0]       mac_a_q, mac_a_d;
    logic [15:0]       mac_b_q, mac_b_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       res_data_q, res_data_d;
    logic              skip_pair;

    // The first pair is never skipped: its issue is what clears the accumulator.
`ifdef DLFLOAT_SEQ_ZERO_SKIP_EN
    always_comb begin
        skip_pair = !first_q && ((a_reg_q[14:0] == 15'd0) || (bus.in_data[14:0] == 15'd0));
    end
`else
    always_comb begin
        skip_pair = 1'b0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        a_reg_d     = a_reg_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        wait_d      = wait_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.len;
                    first_d     = 1'b1;
                    if (bus.len == '0) begin
                        res_data_d = 16'h0000;
                        state_d    = DONE;
                    end else begin
                        state_d = GET_A;
                    end
                end
            end
            GET_A: begin
                if (bus.in_valid) begin
                    a_reg_d = bus.in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.in_valid) begin
                    if (skip_pair) begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                        if (remaining_q <= CNT_W'(1)) begin
                            res_data_d = bus.mac_c;
                            state_d    = DONE;
                        end else begin
                            state_d = GET_A;
                        end
                    end else begin
                        mac_a_d = a_reg_q;
                        mac_b_d = bus.in_data;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                first_d = 1'b0;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                wait_d  = WAIT_W'(MAC_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // mac_c carries this pair's accumulation on the final WAIT cycle.
                if (wait_q <= WAIT_W'(1)) begin
                    if (remaining_q == '0) begin
                        res_data_d = bus.mac_c;
                        state_d    = DONE;
                    end else begin
                        state_d = GET_A;
                    end
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            a_reg_q     <= 16'h0000;
            mac_a_q     <= 16'h0000;
            mac_b_q     <= 16'h0000;
            wait_q      <= '0;
            res_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            a_reg_q     <= a_reg_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            wait_q      <= wait_d;
            res_data_q  <= res_data_d;
        end
    end

    // Control outputs decode straight from state so reset clears them at once.
    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == GET_A) || (state_q == GET_B);
    assign bus.mac_en    = (state_q == ISSUE);
    assign bus.mac_clr   = (state_q == ISSUE) && first_q;
    assign bus.res_valid = (state_q == DONE);
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Self-checking bench for dlfloat_mac_seq: a real-valued MAC model closes the loop and
// expected results come from plain dot-product arithmetic on the generated operands.
module tb_dlfloat_mac_seq;
    localparam int MAC_LAT = 3;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    dlfloat_mac_seq_if #(.CNT_W(CNT_W)) bus ();

    dlfloat_mac_seq #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real dl2real(input logic [15:0] w);
        real m;
        int  e;
        if (w[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(w[8:0]) / 512.0;
        e = int'(w[14:9]) - 31;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return w[15] ? -m : m;
    endfunction

    function automatic logic [15:0] real2dl(input real r);
        logic s;
        real  m;
        int   e;
        int   man;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        man = int'((m - 1.0) * 512.0);
        return {s, 6'(e + 31), 9'(man)};
    endfunction

    // Behavioural MAC: accumulate on mac_en, result appears MAC_LAT cycles later.
    real         acc_r = 0.0;
    real         acc_next;
    logic [15:0] pipe [MAC_LAT];

    always_comb begin
        acc_next = acc_r;
        if (bus.mac_en) begin
            acc_next = (bus.mac_clr ? 0.0 : acc_r) + dl2real(bus.mac_a) * dl2real(bus.mac_b);
        end
    end

    always @(posedge clk) begin
        acc_r   <= acc_next;
        pipe[0] <= real2dl(acc_next);
        for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mac_c = pipe[MAC_LAT-1];

    int          en_cyc [$];
    logic [15:0] en_a [$];
    logic [15:0] en_b [$];
    logic        en_clr [$];

    always @(negedge clk) begin
        if (!rst && bus.mac_en) begin
            en_cyc.push_back(cyc);
            en_a.push_back(bus.mac_a);
            en_b.push_back(bus.mac_b);
            en_clr.push_back(bus.mac_clr);
        end
    end

    logic [15:0] op_a [8];
    logic [15:0] op_b [8];
    logic [15:0] exp_res;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendWord(input logic [15:0] w, input bit gaps);
        int tmo;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tmo = 0;
        while (!bus.in_ready && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        checkOutput("in_ready_seen", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit gaps);
        real         sum;
        bit          skip;
        bit          last_issued;
        logic [15:0] exp_a [$];
        logic [15:0] exp_b [$];
        int          tmo;
        int          rv_cyc;
        en_cyc.delete(); en_a.delete(); en_b.delete(); en_clr.delete();
        sum = 0.0;
        last_issued = 1'b0;
        for (int i = 0; i < n; i++) begin
            sum += dl2real(op_a[i]) * dl2real(op_b[i]);
            skip = 1'b0;
`ifdef DLFLOAT_SEQ_ZERO_SKIP_EN
            skip = (i > 0) && ((op_a[i][14:0] == 15'd0) || (op_b[i][14:0] == 15'd0));
`endif
            if (!skip) begin
                exp_a.push_back(op_a[i]);
                exp_b.push_back(op_b[i]);
            end
            last_issued = !skip;
        end
        exp_res = real2dl(sum);

        bus.start = 1'b1;
        bus.len   = CNT_W'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (n == 0) checkOutput("len0_res_valid_next", 32'(bus.res_valid), 32'd1);
        else        checkOutput("start_in_ready_next", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < n; i++) begin
            sendWord(op_a[i], gaps);
            sendWord(op_b[i], gaps);
        end

        tmo = 0;
        while (!bus.res_valid && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
        end
        rv_cyc = cyc;
        checkOutput("res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("res_data", 32'(bus.res_data), 32'(exp_res));
        checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
        checkOutput("mac_en_count", 32'(en_cyc.size()), 32'(exp_a.size()));
        for (int k = 0; k < en_cyc.size() && k < exp_a.size(); k++) begin
            checkOutput("mac_a", 32'(en_a[k]), 32'(exp_a[k]));
            checkOutput("mac_b", 32'(en_b[k]), 32'(exp_b[k]));
            checkOutput("mac_clr", 32'(en_clr[k]), 32'(k == 0));
            if (k > 0) begin
                checkOutput("mac_en_spacing_ok", 32'((en_cyc[k] - en_cyc[k-1]) >= MAC_LAT + 3), 32'd1);
            end
        end
        if (n > 0 && last_issued && en_cyc.size() > 0) begin
            checkOutput("res_latency", 32'(rv_cyc - en_cyc[en_cyc.size()-1]), 32'(MAC_LAT + 1));
        end
    endtask

    task automatic consumeResult();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checkOutput("res_valid_after_hs", 32'(bus.res_valid), 32'd0);
        checkOutput("busy_after_hs", 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [15:0] randOperand();
        int v;
        v = int'($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 1) v = -v;
        return real2dl(real'(v));
    endfunction

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_mac_en", 32'(bus.mac_en), 32'd0);
        checkOutput("rst_mac_a", 32'(bus.mac_a), 32'h0);
        checkOutput("rst_res_data", 32'(bus.res_data), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single pair 1.0 x 2.0");
        op_a[0] = 16'h3E00; op_b[0] = 16'h4000;
        applyStimulus(1, 1'b0);
        checkOutput("one_pair_value", 32'(bus.res_data), 32'h4000);
        consumeResult();

        $display("[TB] zero-length job");
        applyStimulus(0, 1'b0);
        checkOutput("len0_value", 32'(bus.res_data), 32'h0000);
        consumeResult();

        $display("[TB] three 1.0 x 1.0 pairs with input gaps");
        for (int i = 0; i < 3; i++) begin op_a[i] = 16'h3E00; op_b[i] = 16'h3E00; end
        applyStimulus(3, 1'b1);
        checkOutput("three_ones_value", 32'(bus.res_data), 32'h4100);
        consumeResult();

        $display("[TB] result stall in DONE with start pulses");
        for (int i = 0; i < 2; i++) begin op_a[i] = randOperand(); op_b[i] = randOperand(); end
        applyStimulus(2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bus.start = (k % 2 == 0);
            bus.len   = '0;
            @(posedge clk); #1;
            checkOutput("stall_res_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("stall_res_data", 32'(bus.res_data), 32'(exp_res));
            checkOutput("stall_busy", 32'(bus.busy), 32'd1);
        end
        bus.start     = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        checkOutput("start_with_hs_ignored_busy", 32'(bus.busy), 32'd0);
        checkOutput("start_with_hs_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_stays_idle", 32'(bus.busy), 32'd0);

        $display("[TB] zero operand in second pair");
        op_a[0] = 16'h3E00; op_b[0] = 16'h4000;
        op_a[1] = 16'h0000; op_b[1] = 16'h4100;
        op_a[2] = 16'h3E00; op_b[2] = 16'h3E00;
        applyStimulus(3, 1'b0);
        checkOutput("zero_pair_value", 32'(bus.res_data), 32'h4100);
        consumeResult();

        $display("[TB] reset during WAIT");
        bus.start = 1'b1;
        bus.len   = CNT_W'(1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        sendWord(16'h4000, 1'b0);
        sendWord(16'h4000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("wait_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("wait_rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("wait_rst_mac_a", 32'(bus.mac_a), 32'h0);
        checkOutput("wait_rst_mac_b", 32'(bus.mac_b), 32'h0);
        checkOutput("wait_rst_mac_en", 32'(bus.mac_en), 32'd0);
        checkOutput("wait_rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        checkOutput("wait_rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("wait_rst_res_data", 32'(bus.res_data), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op_a[0] = 16'h4000; op_b[0] = 16'h4100;
        applyStimulus(1, 1'b0);
        consumeResult();

        $display("[TB] random jobs");
        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin op_a[i] = randOperand(); op_b[i] = randOperand(); end
            applyStimulus(n, 1'b1);
            consumeResult();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
